// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states,
// byte-lane write-enable decode and request error classification.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_STORE = 2'd1,
        S_LOAD  = 2'd2,
        S_RESP  = 2'd3
    } lsu_state_t;

    // Byte enables for a store of the given width at the given lane offset.
    function automatic logic [3:0] lane_we(input logic [2:0] funct3, input logic [1:0] off);
        logic [3:0] w;
        case (funct3)
            F3_B:    w = 4'b0001 << off;
            F3_H:    w = 4'b0011 << off;
            F3_W:    w = 4'b1111;
            default: w = 4'b0000;
        endcase
        return w;
    endfunction

    // Illegal funct3 or misalignment; the range check lives with the caller
    // because it depends on the memory size parameter.
    function automatic logic req_bad(input logic store, input logic [2:0] funct3,
                                     input logic [1:0] off);
        logic illegal;
        logic misal;
        if (store) illegal = (funct3 > F3_W);
        else       illegal = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
        misal = ((funct3[1:0] == 2'd1) && off[0]) ||
                ((funct3[1:0] == 2'd2) && (off != 2'd0));
        return illegal || misal;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data extraction: picks the byte/half addressed by the lane offset
// out of the dmem word and sign- or zero-extends it to the full width.
module lsu_load_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] drdata,
    input  logic [1:0]      off,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] rdata
);

    logic [XLEN-1:0] shifted;

    assign shifted = drdata >> {off, 3'b000};

    // Width/sign selection on the lane-shifted word.
    always_comb begin
        rdata = '0;
        case (funct3)
            F3_B:    rdata = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            F3_H:    rdata = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            F3_W:    rdata = drdata;
            F3_BU:   rdata = {{(XLEN-8){1'b0}}, shifted[7:0]};
            F3_HU:   rdata = {{(XLEN-16){1'b0}}, shifted[15:0]};
            default: rdata = '0;
        endcase
    end

endmodule

// File: rtl/lsu_dmem_ctrl.sv
// Load/store unit: accepts one request at a time, performs a single-cycle
// dmem access and returns a response held until the consumer takes it.
module lsu_dmem_ctrl
    import lsu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int DMEM_BYTES = 128
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_store,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic [XLEN-1:0] daddr,
    output logic [XLEN-1:0] dwdata,
    output logic [3:0]      we,
    input  logic [XLEN-1:0] drdata
);

    lsu_state_t      state_q, state_d;
    logic            store_q, store_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            err_q, err_d;

    logic [XLEN-1:0] load_data;
    logic            new_err;

    lsu_load_align #(.XLEN(XLEN)) u_align (
        .drdata (drdata),
        .off    (addr_q[1:0]),
        .funct3 (funct3_q),
        .rdata  (load_data)
    );

    assign new_err = req_bad(req_store, req_funct3, req_addr[1:0]) ||
                     (req_addr >= XLEN'(DMEM_BYTES));

    // State and latched request registers; reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            store_q  <= 1'b0;
            funct3_q <= 3'd0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            store_q  <= store_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Next-state: latch in IDLE, one access cycle, then hold the response.
    always_comb begin
        state_d  = state_q;
        store_d  = store_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    store_d  = req_store;
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    rdata_d  = '0;
                    err_d    = new_err;
                    if (new_err)        state_d = S_RESP;
                    else if (req_store) state_d = S_STORE;
                    else                state_d = S_LOAD;
                end
            end
            S_STORE: state_d = S_RESP;
            S_LOAD: begin
                rdata_d = load_data;
                state_d = S_RESP;
            end
            S_RESP: begin
                if (resp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Write enables come straight from state so reset kills them at once.
    assign we         = (state_q == S_STORE) ? lane_we(funct3_q, addr_q[1:0]) : 4'b0000;
    assign daddr      = addr_q;
    assign dwdata     = wdata_q << {addr_q[1:0], 3'b000};
    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// Self-checking bench for lsu_dmem_ctrl with a byte-array dmem and an
// independent byte-level reference model.
module tb_lsu_dmem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_store = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [3:0]  we;
    logic [31:0] drdata;

    int errors = 0;
    int checks = 0;

    logic [7:0] mem     [0:127];
    logic [7:0] ref_mem [0:127];

    always #5 clk = ~clk;

    lsu_dmem_ctrl #(.XLEN(32), .DMEM_BYTES(128)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .daddr      (daddr),
        .dwdata     (dwdata),
        .we         (we),
        .drdata     (drdata)
    );

    // Environment dmem: combinational read of the addressed word, byte writes.
    assign drdata = {mem[{daddr[6:2], 2'd3}], mem[{daddr[6:2], 2'd2}],
                     mem[{daddr[6:2], 2'd1}], mem[{daddr[6:2], 2'd0}]};

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (we[i]) mem[{daddr[6:2], 2'(i)}] <= dwdata[8*i +: 8];
    end

    // Reference: byte-granular memory, plain arithmetic for sizes and signs.
    function automatic void model(input bit st, input int f3, input int unsigned addr,
                                  input logic [31:0] wd, output bit e,
                                  output logic [31:0] rd, output logic [3:0] wem,
                                  output logic [31:0] dw);
        bit     legal;
        int     size;
        int     wmask;
        longint v;
        longint one = 1;
        legal = st ? (f3 <= 2) : (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
        size  = 1 << (f3 % 4);
        e     = !legal || (addr >= 128) || ((addr % size) != 0);
        rd = 32'd0; wem = 4'd0; dw = 32'd0;
        if (!e) begin
            wmask = ((1 << size) - 1) << (addr % 4);
            wem   = wmask[3:0];
            dw    = wd << (8 * (addr % 4));
            if (st) begin
                for (int b = 0; b < size; b++) ref_mem[addr + b] = wd[8*b +: 8];
            end else begin
                v = 0;
                for (int b = 0; b < size; b++) v += longint'(ref_mem[addr + b]) << (8 * b);
                if ((f3 == 0 || f3 == 1) && v >= (one << (8 * size - 1))) v -= (one << (8 * size));
                rd = v[31:0];
            end
        end
    endfunction

    task automatic check_mem(input string tag);
        int mism = 0;
        for (int i = 0; i < 128; i++) if (mem[i] !== ref_mem[i]) mism++;
        checks++;
        if (mism != 0) begin
            errors++;
            $display("FAIL mem_%s: %0d bytes differ, required 0", tag, mism);
        end
    endtask

    // One full request/response; checks the access cycle and the response.
    task automatic transact(input bit st, input int f3, input int unsigned addr,
                            input logic [31:0] wd, input int stall,
                            output logic [31:0] o_rd, output logic [3:0] o_we,
                            output logic [31:0] o_dw);
        bit          e;
        logic [31:0] x_rd, x_dw;
        logic [3:0]  x_we;
        int          n = 0;
        model(st, f3, addr, wd, e, x_rd, x_we, x_dw);
        @(negedge clk);
        req_valid = 1'b1; req_store = st; req_funct3 = 3'(f3);
        req_addr = addr; req_wdata = wd;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (!req_ready) begin errors++; $display("FAIL ready_timeout: req_ready=%0d required 1", req_ready); end
        @(negedge clk);
        req_valid = 1'b0;
        o_we = we; o_dw = dwdata;
        if (e) begin
            checks++;
            if (we !== 4'd0) begin errors++; $display("FAIL err_we: we=%b required 0000", we); end
            checks++;
            if (resp_valid !== 1'b1) begin errors++; $display("FAIL err_resp_valid: got %b required 1", resp_valid); end
        end else begin
            checks++;
            if (we !== (st ? x_we : 4'd0)) begin errors++; $display("FAIL access_we: got %b required %b", we, st ? x_we : 4'd0); end
            checks++;
            if (daddr !== addr) begin errors++; $display("FAIL access_daddr: got %h required %h", daddr, addr); end
            if (st) begin
                checks++;
                if (dwdata !== x_dw) begin errors++; $display("FAIL access_dwdata: got %h required %h", dwdata, x_dw); end
            end
            checks++;
            if (resp_valid !== 1'b0) begin errors++; $display("FAIL early_resp: resp_valid=%b required 0", resp_valid); end
            @(negedge clk);
            checks++;
            if (resp_valid !== 1'b1) begin errors++; $display("FAIL resp_valid: got %b required 1", resp_valid); end
            checks++;
            if (we !== 4'd0) begin errors++; $display("FAIL resp_we: got %b required 0000", we); end
        end
        checks++;
        if (resp_err !== e) begin errors++; $display("FAIL resp_err: got %b required %b", resp_err, e); end
        checks++;
        if (resp_rdata !== x_rd) begin errors++; $display("FAIL resp_rdata: got %h required %h", resp_rdata, x_rd); end
        checks++;
        if (req_ready !== 1'b0) begin errors++; $display("FAIL resp_req_ready: got %b required 0", req_ready); end
        o_rd = resp_rdata;
        if (stall > 0) begin
            resp_ready = 1'b0;
            req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'd2;
            req_addr = 32'h30; req_wdata = $urandom;
            for (int c = 0; c < stall; c++) begin
                @(negedge clk);
                checks++;
                if (resp_valid !== 1'b1 || resp_rdata !== x_rd || req_ready !== 1'b0 || we !== 4'd0) begin
                    errors++;
                    $display("FAIL stall_hold: valid=%b rdata=%h ready=%b we=%b required 1 %h 0 0000",
                             resp_valid, resp_rdata, req_ready, we, x_rd);
                end
            end
            resp_ready = 1'b1;
            req_valid = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL resp_release: valid=%b ready=%b required 0 1", resp_valid, req_ready);
        end
        $display("txn st=%0d f3=%0d addr=%h wdata=%h rdata=%h err=%0d", st, f3, addr, wd, o_rd, e);
        check_mem("txn");
    endtask

    task automatic test_reset;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_err !== 1'b0 ||
            resp_rdata !== 32'd0 || daddr !== 32'd0 || dwdata !== 32'd0 || we !== 4'd0) begin
            errors++;
            $display("FAIL reset_state: ready=%b valid=%b err=%b rdata=%h daddr=%h dwdata=%h we=%b required 1 0 0 0 0 0 0",
                     req_ready, resp_valid, resp_err, resp_rdata, daddr, dwdata, we);
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", req_ready); end
    endtask

    task automatic test_byte;
        logic [31:0] rd, dw; logic [3:0] w;
        transact(1'b1, 0, 32'h05, 32'hAABBCCDD, 0, rd, w, dw);
        checks++;
        if (w !== 4'b0010 || dw !== 32'hBBCCDD00) begin errors++; $display("FAIL sb_lane: we=%b dwdata=%h required 0010 bbccdd00", w, dw); end
        transact(1'b0, 0, 32'h05, 32'h0, 0, rd, w, dw);
        checks++;
        if (rd !== 32'hFFFFFFDD) begin errors++; $display("FAIL lb: got %h required ffffffdd", rd); end
        transact(1'b0, 4, 32'h05, 32'h0, 0, rd, w, dw);
        checks++;
        if (rd !== 32'h000000DD) begin errors++; $display("FAIL lbu: got %h required 000000dd", rd); end
    endtask

    task automatic test_half;
        logic [31:0] rd, dw; logic [3:0] w;
        transact(1'b1, 1, 32'h06, 32'h00008234, 0, rd, w, dw);
        checks++;
        if (w !== 4'b1100 || dw !== 32'h82340000) begin errors++; $display("FAIL sh_lane: we=%b dwdata=%h required 1100 82340000", w, dw); end
        transact(1'b0, 1, 32'h06, 32'h0, 0, rd, w, dw);
        checks++;
        if (rd !== 32'hFFFF8234) begin errors++; $display("FAIL lh: got %h required ffff8234", rd); end
        transact(1'b0, 5, 32'h06, 32'h0, 0, rd, w, dw);
        checks++;
        if (rd !== 32'h00008234) begin errors++; $display("FAIL lhu: got %h required 00008234", rd); end
    endtask

    task automatic test_word;
        logic [31:0] rd, dw; logic [3:0] w;
        transact(1'b1, 2, 32'h10, 32'hDEADBEEF, 0, rd, w, dw);
        checks++;
        if (w !== 4'b1111) begin errors++; $display("FAIL sw_we: got %b required 1111", w); end
        transact(1'b0, 2, 32'h10, 32'h0, 0, rd, w, dw);
        checks++;
        if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL lw: got %h required deadbeef", rd); end
    endtask

    task automatic test_errors;
        bit          st_t [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        int          f3_t [4] = '{2, 1, 0, 3};
        int unsigned ad_t [4] = '{32'h02, 32'h03, 32'h80, 32'h00};
        logic [31:0] rd, dw; logic [3:0] w;
        for (int i = 0; i < 4; i++) begin
            transact(st_t[i], f3_t[i], ad_t[i], 32'h5A5A5A5A, 0, rd, w, dw);
            checks++;
            if (rd !== 32'd0 || w !== 4'd0) begin errors++; $display("FAIL err_case%0d: rdata=%h we=%b required 0 0000", i, rd, w); end
        end
    endtask

    task automatic test_resp_stall;
        logic [31:0] rd, dw; logic [3:0] w;
        transact(1'b0, 2, 32'h10, 32'h0, 3, rd, w, dw);
    endtask

    task automatic test_reset_mid_store;
        logic [31:0] rd, dw; logic [3:0] w;
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'd2;
        req_addr = 32'h20; req_wdata = 32'h11223344;
        @(negedge clk);
        checks++;
        if (we !== 4'b1111) begin errors++; $display("FAIL rst_store_we: got %b required 1111", we); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (we !== 4'd0 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_abort: we=%b valid=%b ready=%b required 0000 0 1", we, resp_valid, req_ready);
        end
        req_valid = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_release: ready=%b valid=%b required 1 0", req_ready, resp_valid);
        end
        $display("txn reset during SW addr=00000020");
        check_mem("rst");
        transact(1'b0, 2, 32'h20, 32'h0, 0, rd, w, dw);
    endtask

    task automatic test_random;
        logic [31:0] rd, dw; logic [3:0] w;
        int unsigned a;
        for (int i = 0; i < 60; i++) begin
            a = ($urandom_range(0, 9) == 0) ? $urandom_range(128, 300) : $urandom_range(0, 127);
            transact(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), a, $urandom,
                     ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0, rd, w, dw);
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) begin
            mem[i] = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        #2;
        test_reset;
        test_byte;
        test_half;
        test_word;
        test_errors;
        test_resp_stall;
        test_reset_mid_store;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/lsu_dmem_ctrl.md
Name: lsu_dmem_ctrl

Overview:
- Load/store unit between the CPU execute stage and the byte-addressed data memory.
- Accepts one load or store request at a time over a valid/ready handshake.
- Checks alignment and range, then drives daddr, dwdata and the byte enables we[3:0] into dmem.
- For loads, it extracts, sign- or zero-extends and returns the read data over a response handshake.

Parameters:
- XLEN, 32, data/address width.
- DMEM_BYTES, 128, size of dmem in bytes; addresses >= DMEM_BYTES are out of range.

Ports:
- clk  in  1  system clock, all state on posedge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request (IDLE only).
- req_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3: LB/LH/LW/LBU/LHU or SB/SH/SW.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer accepts response.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned, out-of-range or illegal funct3.
- daddr  out  32  dmem address.
- dwdata  out  32  dmem write data, lane-shifted.
- we  out  4  dmem byte write enables.
- drdata  in  32  dmem combinational read data.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - req_ready=1 once in IDLE.
  - resp_valid=0, resp_err=0, resp_rdata=0, daddr=0, dwdata=0, we=0.
  - A reset mid-operation aborts the request.
  - we drops immediately because it is decoded from state.
- States: IDLE, STORE, LOAD, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid at posedge, latch store/funct3/addr/wdata into registers.
  - If the request is an error, go to RESP with err=1.
  - Otherwise go to STORE or LOAD.
- Error check:
  - Illegal funct3: load 3/6/7, store >2.
  - Misaligned: half with addr[0]!=0, word with addr[1:0]!=0.
  - Out of range: addr >= DMEM_BYTES.
  - Errors never assert we.
- STORE (exactly 1 cycle):
  - daddr=latched addr.
  - dwdata = wdata << (8*addr[1:0]), truncated to 32 bits.
  - we: SB = 4'b0001<<addr[1:0]; SH = 4'b0011<<addr[1:0]; SW = 4'b1111.
  - dmem commits at the closing posedge, then go to RESP.
- LOAD (exactly 1 cycle):
  - daddr=latched addr, we=0.
  - At the closing posedge, register extract(drdata) into resp_rdata, then go to RESP.
  - Extraction: byte/half selected by addr[1:0], sign-extended for LB/LH, zero-extended for LBU/LHU; LW passes the word.
- RESP:
  - resp_valid=1, req_ready=0, we=0.
  - resp_rdata/resp_err held stable until resp_valid && resp_ready at posedge, then go to IDLE and clear resp_valid.
- Latency and throughput:
  - Request accepted at edge N; the dmem access cycle runs between edges N and N+1; resp_valid is high from edge N+1.
  - With resp_ready=1, next request accepted at edge N+3, so minimum 3 cycles per access.
- Requests while not IDLE are ignored (req_ready=0); the requester must hold them.
- daddr/dwdata hold their last values outside STORE/LOAD; only we gates writes.

Decomposition:
- Package lsu_pkg holds:
  - funct3 localparams: F3_B=0, F3_H=1, F3_W=2, F3_BU=4, F3_HU=5.
  - State enum lsu_state_t.
  - Function lane_we(funct3, addr[1:0]) returning 4 bits.
- Sub-module lsu_load_align (combinational): drdata, addr[1:0], funct3 -> 32-bit extended data. It is natural to isolate and unit-test.

Test Plan:
1. SB addr 0x05 wdata 0xAABBCCDD -> STORE cycle: daddr=0x05, we=4'b0010, dwdata=0xBBCCDD00. Then LB 0x05 -> resp_rdata 0xFFFFFFDD; LBU 0x05 -> 0x000000DD.
2. SH addr 0x06 wdata 0x00008234 -> we=4'b1100, dwdata=0x82340000. LH 0x06 -> 0xFFFF8234; LHU 0x06 -> 0x00008234.
3. SW 0x10 0xDEADBEEF, LW 0x10 -> we=4'b1111 for one cycle; resp_rdata 0xDEADBEEF, resp_err=0; resp_valid one edge after acceptance.
4. LW 0x02, SH 0x03, SB 0x80 (DMEM_BYTES=128), load funct3=3 -> each gives resp_err=1, resp_rdata=0, we stays 0, memory unchanged.
5. LW with resp_ready low 3 cycles -> resp_valid and resp_rdata stable, req_ready=0, new req_valid ignored. Accepted the cycle after resp_ready rises.
6. rst_n pulsed low during the STORE cycle of SW 0x20 -> we=0 immediately, state IDLE, resp_valid=0, req_ready=1 after release. Word at 0x20 unchanged.
